display_7seg_scanner: RTL and testbench

Memory-mapped, time-multiplexed driver for the board's multi-digit 7-segment display. Holds a 32-bit display value and a control word written by the core over the peripheral bus. Scans one digit at a time at a programmable rate and presents that digit's nibble, an active-low digit select and a blank flag to the downstream nibble-to-segment decoder stage. Supports per-digit enable masking and a global blink mode.

---
 rtl/display_7seg_pkg.sv | 14 +
 rtl/display_scan_timer.sv | 52 +++++
 rtl/display_7seg_scanner.sv | 112 +++++++++++
 tb/tb_display_7seg_scanner.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/display_7seg_pkg.sv
// Shared constants for the 7-segment scanner: bus address map and
// CONTROL register layout.
package display_7seg_pkg;

    localparam logic ADDR_VALUE   = 1'b0;
    localparam logic ADDR_CONTROL = 1'b1;

    localparam int unsigned MASK_LSB  = 0;
    localparam int unsigned MASK_MSB  = 7;
    localparam int unsigned BLINK_BIT = 8;

    localparam logic [31:0] CONTROL_RESET = 32'h0000_00FF;

endpackage

// File: rtl/display_scan_timer.sv
// Scan timing for the 7-segment scanner: digit-slot prescaler, frame counter
// and blink phase.
module display_scan_timer #(
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic last_digit,
    output logic tick,
    output logic frame_end,
    output logic blink_phase
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0] count_q, count_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          phase_q, phase_d;
    logic          frame_wrap;

    always_comb begin
        tick       = (count_q == PW'(PRESCALE - 1));
        frame_end  = tick & last_digit;
        frame_wrap = (frame_q == FW'(BLINK_FRAMES - 1));
        count_d    = tick ? '0 : count_q + 1'b1;
        frame_d    = frame_q;
        phase_d    = phase_q;
        if (frame_end) begin
            frame_d = frame_wrap ? '0 : frame_q + 1'b1;
            if (frame_wrap) begin
                phase_d = ~phase_q;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            frame_q <= '0;
            phase_q <= 1'b0;
        end else begin
            count_q <= count_d;
            frame_q <= frame_d;
            phase_q <= phase_d;
        end
    end

    assign blink_phase = phase_q;

endmodule

// File: rtl/display_7seg_scanner.sv
// Memory-mapped multiplexed 7-segment scanner: VALUE/CONTROL registers, digit
// index and registered nibble/select/blank outputs for the segment decoder.
module display_7seg_scanner
    import display_7seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  bus_write_enable,
    input  logic                  bus_read_enable,
    input  logic                  bus_address,
    input  logic [31:0]           bus_write_data,
    output logic [31:0]           bus_read_data,
    output logic [3:0]            digit_nibble,
    output logic [NUM_DIGITS-1:0] digit_select,
    output logic                  digit_blank
);

    localparam logic [NUM_DIGITS-1:0] SELECT_RESET = ~NUM_DIGITS'(1);

    logic [31:0]           value_q, value_d;
    logic [7:0]            mask_q, mask_d;
    logic                  blink_en_q, blink_en_d;
    logic [2:0]            index_q, index_d;
    logic [31:0]           rd_data_q, rd_data_d;
    logic [3:0]            nibble_q, nibble_d;
    logic [NUM_DIGITS-1:0] select_q, select_d;
    logic                  blank_q, blank_d;
    logic [31:0]           control_word;
    logic                  last_digit, tick, frame_end, blink_phase;

    assign last_digit = (index_q == 3'(NUM_DIGITS - 1));

    display_scan_timer #(
        .PRESCALE    (PRESCALE),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .last_digit (last_digit),
        .tick       (tick),
        .frame_end  (frame_end),
        .blink_phase(blink_phase)
    );

    always_comb begin
        control_word                    = '0;
        control_word[MASK_MSB:MASK_LSB] = mask_q;
        control_word[BLINK_BIT]         = blink_en_q;

        value_d    = value_q;
        mask_d     = mask_q;
        blink_en_d = blink_en_q;
        if (bus_write_enable) begin
            if (bus_address == ADDR_CONTROL) begin
                mask_d     = bus_write_data[MASK_MSB:MASK_LSB];
                blink_en_d = bus_write_data[BLINK_BIT];
            end else begin
                value_d = bus_write_data;
            end
        end

        // Reads sample the pre-write register contents, so a same-cycle
        // read+write returns the old value.
        rd_data_d = '0;
        if (bus_read_enable) begin
            rd_data_d = (bus_address == ADDR_CONTROL) ? control_word : value_q;
        end

        index_d = index_q;
        if (tick) begin
            index_d = last_digit ? '0 : index_q + 3'd1;
        end

        nibble_d = value_q[{index_q, 2'b00} +: 4];
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            select_d[i] = (index_q != 3'(i));
        end
        blank_d = ~mask_q[index_q] | (blink_en_q & blink_phase);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value_q    <= '0;
            mask_q     <= CONTROL_RESET[MASK_MSB:MASK_LSB];
            blink_en_q <= CONTROL_RESET[BLINK_BIT];
            index_q    <= '0;
            rd_data_q  <= '0;
            nibble_q   <= '0;
            select_q   <= SELECT_RESET;
            blank_q    <= 1'b0;
        end else begin
            value_q    <= value_d;
            mask_q     <= mask_d;
            blink_en_q <= blink_en_d;
            index_q    <= index_d;
            rd_data_q  <= rd_data_d;
            nibble_q   <= nibble_d;
            select_q   <= select_d;
            blank_q    <= blank_d;
        end
    end

    assign bus_read_data = rd_data_q;
    assign digit_nibble  = nibble_q;
    assign digit_select  = select_q;
    assign digit_blank   = blank_q;

endmodule

// File: tb/tb_display_7seg_scanner.sv
// Directed bench for display_7seg_scanner with 4 digits, 4-cycle slots and
// 2-frame blink half-period (32 cycles).
module tb_display_7seg_scanner;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        bus_write_enable = 1'b0;
    logic        bus_read_enable = 1'b0;
    logic        bus_address = 1'b0;
    logic [31:0] bus_write_data = '0;
    logic [31:0] bus_read_data;
    logic [3:0]  digit_nibble;
    logic [3:0]  digit_select;
    logic        digit_blank;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] m_value;
    logic [7:0]  m_mask;
    logic        m_blink;
    bit          pend_wr = 1'b0;
    logic        pend_addr;
    logic [31:0] pend_data;

    display_7seg_scanner #(
        .NUM_DIGITS  (4),
        .PRESCALE    (4),
        .BLINK_FRAMES(2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .bus_write_enable(bus_write_enable),
        .bus_read_enable (bus_read_enable),
        .bus_address     (bus_address),
        .bus_write_data  (bus_write_data),
        .bus_read_data   (bus_read_data),
        .digit_nibble    (digit_nibble),
        .digit_select    (digit_select),
        .digit_blank     (digit_blank)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
        end
    endtask

    // Outputs seen after edge c reflect the index/phase held before that edge.
    task automatic check_outputs();
        int          d;
        int          ph;
        logic [3:0]  one;
        logic [31:0] nib;
        logic        blank;
        d     = ((cyc - 1) / 4) % 4;
        ph    = ((cyc - 1) / 32) % 2;
        one   = 4'b0001;
        nib   = (m_value >> (4 * d)) & 32'h0000_000F;
        blank = ~m_mask[d] | (m_blink & (ph == 1));
        check_eq("digit_select", {28'b0, digit_select}, {28'b0, ~(one << d)});
        check_eq("digit_nibble", {28'b0, digit_nibble}, nib);
        check_eq("digit_blank", {31'b0, digit_blank}, {31'b0, blank});
    endtask

    task automatic step();
        @(posedge clock);
        cyc++;
        @(negedge clock);
        check_outputs();
        if (pend_wr) begin
            if (pend_addr == 1'b0) begin
                m_value = pend_data;
            end else begin
                m_mask  = pend_data[7:0];
                m_blink = pend_data[8];
            end
            pend_wr = 1'b0;
        end
        bus_write_enable = 1'b0;
        bus_read_enable  = 1'b0;
    endtask

    task automatic bus_write(input logic a, input logic [31:0] d);
        bus_write_enable = 1'b1;
        bus_address      = a;
        bus_write_data   = d;
        pend_wr          = 1'b1;
        pend_addr        = a;
        pend_data        = d;
    endtask

    task automatic bus_read(input logic a);
        bus_read_enable = 1'b1;
        bus_address     = a;
    endtask

    task automatic model_reset();
        m_value = '0;
        m_mask  = 8'hFF;
        m_blink = 1'b0;
        cyc     = 0;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_eq("reset_select", {28'b0, digit_select}, 32'h0000_000E);
        check_eq("reset_nibble", {28'b0, digit_nibble}, 32'h0);
        check_eq("reset_blank", {31'b0, digit_blank}, 32'h0);
        check_eq("reset_read_data", bus_read_data, 32'h0);
        model_reset();
        reset = 1'b0;

        repeat (20) step();

        bus_write(1'b0, 32'h0000_A3F5);
        step();
        repeat (17) step();

        bus_write(1'b1, 32'h0000_0005);
        step();
        repeat (16) step();
        bus_read(1'b1);
        step();
        check_eq("read_control_05", bus_read_data, 32'h0000_0005);
        step();
        check_eq("read_idle_zero", bus_read_data, 32'h0);

        bus_write(1'b1, 32'h0000_01FF);
        step();
        repeat (70) step();
        for (int i = 0; i < 64 && ((cyc / 32) % 2) != 1; i++) step();
        bus_write(1'b1, 32'h0000_00FF);
        step();
        check_eq("blank_before_clear", {31'b0, digit_blank}, 32'h1);
        step();
        check_eq("blank_cleared", {31'b0, digit_blank}, 32'h0);

        bus_write(1'b1, 32'hFFFF_FFFF);
        step();
        bus_read(1'b1);
        step();
        check_eq("read_control_ones", bus_read_data, 32'h0000_01FF);

        bus_write(1'b0, 32'h1234_5678);
        bus_read_enable = 1'b1;
        step();
        check_eq("read_during_write", bus_read_data, 32'h0000_A3F5);
        bus_read(1'b0);
        step();
        check_eq("read_value_new", bus_read_data, 32'h1234_5678);
        repeat (8) step();

        for (int i = 0; i < 32 && !((((cyc - 1) / 4) % 4) == 2 && ((cyc - 1) % 4) == 1); i++) step();
        check_eq("pre_reset_digit2", {28'b0, digit_select}, 32'h0000_000B);
        reset = 1'b1;
        #1;
        check_eq("async_reset_select", {28'b0, digit_select}, 32'h0000_000E);
        check_eq("async_reset_nibble", {28'b0, digit_nibble}, 32'h0);
        check_eq("async_reset_blank", {31'b0, digit_blank}, 32'h0);
        check_eq("async_reset_read", bus_read_data, 32'h0);
        @(negedge clock);
        model_reset();
        reset = 1'b0;
        repeat (24) step();
        bus_read(1'b1);
        step();
        check_eq("control_after_reset", bus_read_data, 32'h0000_00FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
